// File: rtl/bcd_timer_ud_n_pkg.sv
// bcd_timer_ud_n_pkg: shared constants and helpers for the BCD up/down timer.
package bcd_timer_ud_n_pkg;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int INNER_MOD = 60;
   function automatic int presc_width(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction
   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction
   // Packed BCD compares correctly once both digits are known to be <= 9
   function automatic logic [7:0] clamp_stage(input logic [7:0] v, input int modulus);
      logic [7:0] top;
      top = to_bcd(modulus - 1);
      return (v[7:4] > BCD_MAX || v[3:0] > BCD_MAX || v > top) ? top : v;
   endfunction
endpackage

// File: rtl/bcd_timer_ud_n_if.sv
// bcd_timer_ud_n_if: control and display bundle between a timer user and the timer.
interface bcd_timer_ud_n_if #(parameter int STAGES = 3) ();
   logic enable, dir, load, step_up, step_dn;
   logic [8*STAGES-1:0] load_value, bcd_out;
   logic tick_out, zero, wrap_p, done_p;
   modport master (
      output enable, dir, load, load_value, step_up, step_dn,
      input bcd_out, tick_out, zero, wrap_p, done_p
   );
   modport slave (
      input enable, dir, load, load_value, step_up, step_dn,
      output bcd_out, tick_out, zero, wrap_p, done_p
   );
endinterface

// File: rtl/bcd_timer_ud_n_stage.sv
// bcd_stage_ud: one two-digit BCD stage counting modulo MOD with carry/borrow out.
module bcd_stage_ud
   import bcd_timer_ud_n_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic [7:0] val_o,
   output logic       is_max_o,
   output logic       is_zero_o,
   output logic       carry_o,
   output logic       borrow_o
);
   localparam logic [7:0] MAX_V = to_bcd(MOD - 1);
   logic [7:0] val_q, val_d, inc_v, dec_v;
   always_comb begin
      inc_v = is_max_o ? 8'h00 : (val_q[3:0] == BCD_MAX) ? {val_q[7:4] + 4'd1, 4'd0} : val_q + 8'd1;
      dec_v = is_zero_o ? MAX_V : (val_q[3:0] == 4'd0) ? {val_q[7:4] - 4'd1, BCD_MAX} : val_q - 8'd1;
      val_d = load_i ? clamp_stage(load_val_i, MOD) : inc_i ? inc_v : dec_i ? dec_v : val_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else val_q <= val_d;
   end
   assign val_o = val_q;
   assign is_max_o = val_q == MAX_V;
   assign is_zero_o = val_q == 8'h00;
   assign carry_o = inc_i && is_max_o;
   assign borrow_o = dec_i && is_zero_o;
endmodule

// File: rtl/bcd_timer_ud_n.sv
// bcd_timer_ud_n: prescaled multi-stage BCD up/down timer with load clamp, manual steps and flags.
module bcd_timer_ud_n
   import bcd_timer_ud_n_pkg::*;
#(
   parameter int CLK_MHZ = 125,
   parameter int TICK_US = 1000000,
   parameter int STAGES  = 3,
   parameter int TOP_MOD = 24
) (
   input logic clk,
   input logic reset_n,
   bcd_timer_ud_n_if.slave bus
);
   localparam int TICKS = CLK_MHZ * TICK_US;
   localparam int PW = presc_width(TICKS);
   localparam logic [PW-1:0] PRESC_T = PW'(TICKS - 1);
   logic [PW-1:0] presc_q, presc_d;
   logic tick_q, wrap_q, done_q, tick_d, wrap_d, done_d;
   logic tick, step_ok, inc0, dec0, all_zero;
   logic [STAGES:0] inc_c, dec_c;
   logic [STAGES-1:0] is_max, is_zero;
   logic [8*STAGES-1:0] bcd;
   logic [1:0] unused_chain_out;
   assign inc_c[0] = inc0;
   assign dec_c[0] = dec0;
   assign unused_chain_out = {inc_c[STAGES], dec_c[STAGES]};
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      bcd_stage_ud #(.MOD((s == STAGES - 1) ? TOP_MOD : INNER_MOD)) u_stage (
         .clk       (clk),
         .rst_n     (reset_n),
         .inc_i     (inc_c[s]),
         .dec_i     (dec_c[s]),
         .load_i    (bus.load),
         .load_val_i(bus.load_value[8*s +: 8]),
         .val_o     (bcd[8*s +: 8]),
         .is_max_o  (is_max[s]),
         .is_zero_o (is_zero[s]),
         .carry_o   (inc_c[s+1]),
         .borrow_o  (dec_c[s+1])
      );
   end
   // Steps only exist while paused and ticks only while running, so they never collide
   always_comb begin
      tick = bus.enable && presc_q == PRESC_T;
      step_ok = !bus.enable && (bus.step_up ^ bus.step_dn);
      all_zero = &is_zero;
      inc0 = !bus.load && ((step_ok && bus.step_up) || (tick && bus.dir));
      dec0 = !bus.load && ((step_ok && bus.step_dn) || (tick && !bus.dir && !all_zero));
      presc_d = (bus.load || tick) ? '0 : bus.enable ? presc_q + PW'(1) : presc_q;
      tick_d = tick && !bus.load;
      wrap_d = tick_d && bus.dir && &is_max;
      done_d = dec0 && bus.enable && bcd == (8*STAGES)'(1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
         done_q <= done_d;
      end
   end
   assign bus.bcd_out = bcd;
   assign bus.zero = all_zero;
   assign bus.tick_out = tick_q;
   assign bus.wrap_p = wrap_q;
   assign bus.done_p = done_q;
endmodule

// File: tb/tb_bcd_timer_ud_n.sv
// tb_bcd_timer_ud_n: directed scenarios checked against an integer-count model every cycle.
module tb_bcd_timer_ud_n;
   localparam int STAGES = 3;
   localparam int TOP_MOD = 24;
   localparam int TICKS = 4;
   localparam int MAXN = TOP_MOD * 60 * 60 - 1;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int n_pass = 0;
   int n_total = 0;
   int m_n, m_pre;
   logic m_tick, m_wrap, m_done;

   bcd_timer_ud_n_if #(.STAGES(STAGES)) bus ();
   bcd_timer_ud_n #(.CLK_MHZ(1), .TICK_US(TICKS), .STAGES(STAGES), .TOP_MOD(TOP_MOD)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int modulus(input int s);
      return (s == STAGES - 1) ? TOP_MOD : 60;
   endfunction

   function automatic int from_bcd(input logic [8*STAGES-1:0] b);
      int n, w, t, o, v;
      n = 0;
      w = 1;
      for (int s = 0; s < STAGES; s++) begin
         t = int'(b[8*s+4 +: 4]);
         o = int'(b[8*s +: 4]);
         v = t * 10 + o;
         if (t > 9 || o > 9 || v >= modulus(s)) v = modulus(s) - 1;
         n += v * w;
         w *= modulus(s);
      end
      return n;
   endfunction

   function automatic logic [8*STAGES-1:0] to_bcd(input int n);
      logic [8*STAGES-1:0] r;
      int v;
      r = '0;
      for (int s = 0; s < STAGES; s++) begin
         v = n % modulus(s);
         n = n / modulus(s);
         r[8*s +: 8] = {4'(v / 10), 4'(v % 10)};
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_n <= 0;
         m_pre <= 0;
         m_tick <= 1'b0;
         m_wrap <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_tick <= 1'b0;
         m_wrap <= 1'b0;
         m_done <= 1'b0;
         if (bus.load) begin
            m_n <= from_bcd(bus.load_value);
            m_pre <= 0;
         end else if (bus.enable) begin
            if (m_pre == TICKS - 1) begin
               m_pre <= 0;
               m_tick <= 1'b1;
               if (bus.dir) begin
                  m_n <= (m_n == MAXN) ? 0 : m_n + 1;
                  m_wrap <= m_n == MAXN;
               end else if (m_n != 0) begin
                  m_n <= m_n - 1;
                  m_done <= m_n == 1;
               end
            end else m_pre <= m_pre + 1;
         end else if (bus.step_up != bus.step_dn) begin
            m_n <= bus.step_up ? (m_n + 1) % (MAXN + 1) : (m_n + MAXN) % (MAXN + 1);
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("model_count", 32'(bus.bcd_out), 32'(to_bcd(m_n)));
         check("model_flags", {28'd0, bus.tick_out, bus.wrap_p, bus.done_p, bus.zero},
               {28'd0, m_tick, m_wrap, m_done, m_n == 0});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [8*STAGES-1:0] v);
      bus.load = 1'b1;
      bus.load_value = v;
      cyc(1);
      bus.load = 1'b0;
   endtask

   task automatic lit(input string name, input logic [23:0] cnt, input logic [3:0] flags);
      check({name, "_count"}, 32'(bus.bcd_out), 32'(cnt));
      check({name, "_flags"}, {28'd0, bus.tick_out, bus.wrap_p, bus.done_p, bus.zero}, {28'd0, flags});
   endtask

   // flags argument order below: {tick_out, wrap_p, done_p, zero}
   initial begin
      bus.enable = 1'b0;
      bus.dir = 1'b0;
      bus.load = 1'b0;
      bus.load_value = '0;
      bus.step_up = 1'b0;
      bus.step_dn = 1'b0;
      #1 lit("reset", 24'h000000, 4'b0001);
      @(negedge clk);
      reset_n = 1'b1;
      bus.enable = 1'b1;
      bus.dir = 1'b1;
      do_load(24'h235959);
      lit("up_loaded", 24'h235959, 4'b0000);
      cyc(3);
      lit("up_before_tick", 24'h235959, 4'b0000);
      cyc(1);
      lit("up_wrap", 24'h000000, 4'b1101);
      cyc(1);
      lit("up_wrap_end", 24'h000000, 4'b0001);
      bus.dir = 1'b0;
      do_load(24'h000002);
      cyc(4);
      lit("dn_one", 24'h000001, 4'b1000);
      cyc(4);
      lit("dn_done", 24'h000000, 4'b1011);
      cyc(1);
      lit("dn_done_end", 24'h000000, 4'b0001);
      cyc(12);
      lit("dn_hold", 24'h000000, 4'b0001);
      do_load(24'h010000);
      cyc(4);
      lit("borrow_chain", 24'h005959, 4'b1000);
      bus.enable = 1'b0;
      do_load(24'h000000);
      bus.step_dn = 1'b1;
      cyc(1);
      bus.step_dn = 1'b0;
      lit("step_dn_wrap", 24'h235959, 4'b0000);
      do_load(24'h000059);
      bus.step_up = 1'b1;
      cyc(1);
      bus.step_up = 1'b0;
      lit("step_up_carry", 24'h000100, 4'b0000);
      do_load(24'h307A99);
      lit("load_clamp", 24'h235959, 4'b0000);
      bus.step_up = 1'b1;
      do_load(24'h121212);
      bus.step_up = 1'b0;
      lit("load_beats_step", 24'h121212, 4'b0000);
      bus.step_up = 1'b1;
      bus.step_dn = 1'b1;
      cyc(1);
      bus.step_up = 1'b0;
      bus.step_dn = 1'b0;
      lit("both_steps", 24'h121212, 4'b0000);
      bus.enable = 1'b1;
      bus.step_up = 1'b1;
      cyc(1);
      bus.step_up = 1'b0;
      lit("step_while_run", 24'h121212, 4'b0000);
      bus.dir = 1'b1;
      do_load(24'h000000);
      cyc(4);
      lit("pause_first", 24'h000001, 4'b1000);
      cyc(2);
      bus.enable = 1'b0;
      cyc(10);
      bus.enable = 1'b1;
      cyc(1);
      lit("pause_resume1", 24'h000001, 4'b0000);
      cyc(1);
      lit("pause_resume2", 24'h000002, 4'b1000);
      do_load(24'h123456);
      cyc(2);
      #2 reset_n = 1'b0;
      #1 lit("async_reset", 24'h000000, 4'b0001);
      #1 reset_n = 1'b1;
      cyc(3);
      lit("post_reset3", 24'h000000, 4'b0001);
      cyc(1);
      lit("post_reset4", 24'h000001, 4'b1000);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
